// File: rtl/dm_pkg.sv
// Shared debug-transport types: DMI op codes, request/response records and
// the DTMCS field layout used by the JTAG data-register back end.
package dm_pkg;

  typedef enum logic [1:0] {
    DtmNop   = 2'd0,
    DtmRead  = 2'd1,
    DtmWrite = 2'd2
  } dtm_op_e;

  localparam logic [1:0] DmiRespSuccess = 2'd0;
  localparam logic [1:0] DmiRespFailed  = 2'd2;
  localparam logic [1:0] DmiRespBusy    = 2'd3;

  localparam logic [3:0] DtmVersion = 4'd1;

  typedef struct packed {
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

endpackage

// File: rtl/dmi_jtag_dr.sv
// DTMCS and DMI data registers of the debug transport module; turns completed
// DMI scans into a valid/ready request/response exchange with the debug module.
module dmi_jtag_dr
  import dm_pkg::*;
#(
  parameter int unsigned AddrWidth  = 7,
  parameter logic [2:0]  IdleCycles = 3'd1
) (
  input  logic                 tck_i,
  input  logic                 trst_i,
  input  logic                 capture_i,
  input  logic                 shift_i,
  input  logic                 update_i,
  input  logic                 tdi_i,
  input  logic                 dtmcs_select_i,
  output logic                 dtmcs_tdo_o,
  input  logic                 dmi_select_i,
  output logic                 dmi_tdo_o,
  output logic                 dmi_clear_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [1:0]           dmi_req_op_o,
  output logic [31:0]          dmi_req_data_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_resp_i
);

  localparam int unsigned DmiWidth = AddrWidth + 34;

  typedef enum logic [2:0] {
    Idle,
    Read,
    WaitRead,
    Write,
    WaitWrite
  } state_e;

  state_e               state_q;
  logic [31:0]          dtmcs_q;
  logic [DmiWidth-1:0]  dmi_q;
  logic [AddrWidth-1:0] address_q;
  logic [31:0]          data_q;
  logic [1:0]           error_q;
  logic [1:0]           error_d;
  logic                 clear_q;

  dtmcs_t    dtmcs_capture;
  dmi_req_t  dmi_req;
  dmi_resp_t dmi_resp;

  logic       dtmcs_update;
  logic       dmi_update;
  logic       dmi_capture;
  logic       hardreset;
  logic       dmireset;
  logic       busy;
  logic       resp_fire;
  logic [1:0] dmi_op;

  assign dtmcs_update = update_i & dtmcs_select_i;
  assign dmi_update   = update_i & dmi_select_i;
  assign dmi_capture  = capture_i & dmi_select_i;
  assign hardreset    = dtmcs_update & dtmcs_q[17];
  assign dmireset     = dtmcs_update & dtmcs_q[16];
  assign busy         = (state_q != Idle);
  assign dmi_op       = dmi_q[1:0];

  assign dmi_resp  = '{data: dmi_resp_data_i, resp: dmi_resp_resp_i};
  assign resp_fire = dmi_resp_ready_o & dmi_resp_valid_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    dtmcs_capture         = '0;
    dtmcs_capture.idle    = IdleCycles;
    dtmcs_capture.dmistat = error_q;
    dtmcs_capture.abits   = 6'(AddrWidth);
    dtmcs_capture.version = DtmVersion;
  end

  // Sticky status: a response error lands first, busy only fills a clean
  // slot, and either reset strobe wipes whatever was there.
  always_comb begin
    error_d = error_q;
    if (resp_fire && dmi_resp.resp != DmiRespSuccess && error_d == DmiRespSuccess) begin
      error_d = dmi_resp.resp;
    end
    if ((dmi_update || dmi_capture) && busy && error_d == DmiRespSuccess) begin
      error_d = DmiRespBusy;
    end
    if (hardreset || dmireset) begin
      error_d = DmiRespSuccess;
    end
  end

  always_comb begin
    dmi_req = '{op: DtmNop, data: data_q};
    if (state_q == Read) begin
      dmi_req.op = DtmRead;
    end else if (state_q == Write) begin
      dmi_req.op = DtmWrite;
    end
  end

  assign dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
  assign dmi_resp_ready_o = (state_q == WaitRead) || (state_q == WaitWrite);
  assign dmi_req_addr_o   = address_q;
  assign dmi_req_op_o     = dmi_req.op;
  assign dmi_req_data_o   = dmi_req.data;
  assign dmi_clear_o      = clear_q;
  assign dtmcs_tdo_o      = dtmcs_q[0];
  assign dmi_tdo_o        = dmi_q[0];

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      dtmcs_q <= '0;
    end else if (dtmcs_select_i) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (capture_i) begin
        dtmcs_q <= dtmcs_capture;
      end else if (shift_i) begin
        dtmcs_q <= {tdi_i, dtmcs_q[31:1]};
      end
    end
  end

  // A capture during an outstanding transaction reports busy in the op field.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      dmi_q <= '0;
    end else if (dmi_select_i) begin
      if (capture_i) begin
        dmi_q <= {address_q, data_q, (busy ? DmiRespBusy : error_q)};
      end else if (shift_i) begin
        dmi_q <= {tdi_i, dmi_q[DmiWidth-1:1]};
      end
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q   <= Idle;
      address_q <= '0;
      data_q    <= '0;
      error_q   <= DmiRespSuccess;
      clear_q   <= 1'b0;
    end else begin
      error_q <= error_d;
      clear_q <= hardreset;
      if (hardreset) begin
        state_q <= Idle;
      end else begin
        unique case (state_q)
          Idle: begin
            if (dmi_update && error_q == DmiRespSuccess) begin
              case (dmi_op)
                DtmRead: begin
                  address_q <= dmi_q[DmiWidth-1:34];
                  state_q   <= Read;
                end
                DtmWrite: begin
                  address_q <= dmi_q[DmiWidth-1:34];
                  data_q    <= dmi_q[33:2];
                  state_q   <= Write;
                end
                default: ;
              endcase
            end
          end
          Read: begin
            if (dmi_req_ready_i) begin
              state_q <= WaitRead;
            end
          end
          Write: begin
            if (dmi_req_ready_i) begin
              state_q <= WaitWrite;
            end
          end
          WaitRead: begin
            if (dmi_resp_valid_i) begin
              data_q  <= dmi_resp.data;
              state_q <= Idle;
            end
          end
          WaitWrite: begin
            if (dmi_resp_valid_i) begin
              state_q <= Idle;
            end
          end
          default: state_q <= Idle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Self-checking bench for dmi_jtag_dr: scans DTMCS/DMI through a modelled TAP
// sequence and scores captured streams and DMI requests against queued expectations.
module tb_dmi_jtag_dr;

  localparam int AW = 7;
  localparam int DW = AW + 34;

  logic          tck_i = 1'b0;
  logic          trst_i = 1'b1;
  logic          capture_i = 1'b0;
  logic          shift_i = 1'b0;
  logic          update_i = 1'b0;
  logic          tdi_i = 1'b0;
  logic          dtmcs_select_i = 1'b0;
  logic          dtmcs_tdo_o;
  logic          dmi_select_i = 1'b0;
  logic          dmi_tdo_o;
  logic          dmi_clear_o;
  logic          dmi_req_valid_o;
  logic          dmi_req_ready_i = 1'b0;
  logic [AW-1:0] dmi_req_addr_o;
  logic [1:0]    dmi_req_op_o;
  logic [31:0]   dmi_req_data_o;
  logic          dmi_resp_valid_i = 1'b0;
  logic          dmi_resp_ready_o;
  logic [31:0]   dmi_resp_data_i = '0;
  logic [1:0]    dmi_resp_resp_i = '0;

  dmi_jtag_dr #(.AddrWidth(AW), .IdleCycles(3'd1)) dut (
    .tck_i            (tck_i),
    .trst_i           (trst_i),
    .capture_i        (capture_i),
    .shift_i          (shift_i),
    .update_i         (update_i),
    .tdi_i            (tdi_i),
    .dtmcs_select_i   (dtmcs_select_i),
    .dtmcs_tdo_o      (dtmcs_tdo_o),
    .dmi_select_i     (dmi_select_i),
    .dmi_tdo_o        (dmi_tdo_o),
    .dmi_clear_o      (dmi_clear_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_addr_o   (dmi_req_addr_o),
    .dmi_req_op_o     (dmi_req_op_o),
    .dmi_req_data_o   (dmi_req_data_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_data_i  (dmi_resp_data_i),
    .dmi_resp_resp_i  (dmi_resp_resp_i)
  );

  always #5 tck_i = ~tck_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    op;
    logic [31:0]   data;
  } req_t;

  req_t          exp_req_q[$];
  logic [DW-1:0] exp_dmi_q[$];
  logic [31:0]   exp_dtmcs_q[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic req_t pop_req();
    req_t r;
    r = 'x;
    if (exp_req_q.size() > 0) r = exp_req_q.pop_front();
    return r;
  endfunction

  function automatic logic [DW-1:0] pop_dmi();
    logic [DW-1:0] r;
    r = 'x;
    if (exp_dmi_q.size() > 0) r = exp_dmi_q.pop_front();
    return r;
  endfunction

  function automatic logic [31:0] pop_dtmcs();
    logic [31:0] r;
    r = 'x;
    if (exp_dtmcs_q.size() > 0) r = exp_dtmcs_q.pop_front();
    return r;
  endfunction

  function automatic logic [AW+34:0] req_obs();
    return {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o};
  endfunction

  function automatic logic [AW+38:0] all_outs();
    return {dtmcs_tdo_o, dmi_tdo_o, dmi_clear_o, dmi_req_valid_o, dmi_resp_ready_o,
            dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge tck_i);
    #1;
  endtask

  task automatic scan_dtmcs(input logic [31:0] din, output logic [31:0] dout);
    dtmcs_select_i = 1'b1;
    dmi_select_i   = 1'b0;
    capture_i = 1'b1; tick(); capture_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dout[i] = dtmcs_tdo_o;
      tdi_i   = din[i];
      shift_i = 1'b1;
      tick();
    end
    shift_i = 1'b0;
    update_i = 1'b1; tick(); update_i = 1'b0;
    dtmcs_select_i = 1'b0;
  endtask

  task automatic scan_dmi(input logic [DW-1:0] din, output logic [DW-1:0] dout);
    dmi_select_i   = 1'b1;
    dtmcs_select_i = 1'b0;
    capture_i = 1'b1; tick(); capture_i = 1'b0;
    for (int i = 0; i < DW; i++) begin
      dout[i] = dmi_tdo_o;
      tdi_i   = din[i];
      shift_i = 1'b1;
      tick();
    end
    shift_i = 1'b0;
    update_i = 1'b1; tick(); update_i = 1'b0;
    dmi_select_i = 1'b0;
  endtask

  task automatic accept();
    dmi_req_ready_i = 1'b1; tick(); dmi_req_ready_i = 1'b0;
  endtask

  // Waits (bounded) for response-ready, then returns one response beat.
  task automatic respond(input logic [31:0] rdata, input logic [1:0] rcode, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (dmi_resp_ready_o) ok = 1'b1;
      else tick();
    end
    if (ok) begin
      dmi_resp_valid_i = 1'b1;
      dmi_resp_data_i  = rdata;
      dmi_resp_resp_i  = rcode;
      tick();
      dmi_resp_valid_i = 1'b0;
      dmi_resp_resp_i  = 2'd0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL reset_async: got %h want 0", all_outs());
    end
    @(negedge tck_i); trst_i = 1'b0;
    tick();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL reset_release: got %h want 0", all_outs());
    end
  endtask

  task automatic test_dtmcs();
    logic [31:0] dout, e;
    exp_dtmcs_q.push_back(32'h0000_1071);
    scan_dtmcs(32'h0, dout);
    e = pop_dtmcs();
    n_cmp++;
    if (dout !== e) begin
      n_err++; $display("FAIL dtmcs_capture: got %h want %h", dout, e);
    end
  endtask

  task automatic test_dmi_write();
    logic [DW-1:0] dout, ed;
    logic [31:0]   dd;
    req_t          e;
    logic          ok;
    exp_dmi_q.push_back({7'h00, 32'h0, 2'b00});
    exp_req_q.push_back('{addr: 7'h10, op: 2'd2, data: 32'hDEAD_BEEF});
    scan_dmi({7'h10, 32'hDEAD_BEEF, 2'b10}, dout);
    ed = pop_dmi();
    n_cmp++;
    if (dout !== ed) begin
      n_err++; $display("FAIL write_capture: got %h want %h", dout, ed);
    end
    e = pop_req();
    n_cmp++;
    if (req_obs() !== {1'b1, e}) begin
      n_err++; $display("FAIL write_req: got %h want %h", req_obs(), {1'b1, e});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (req_obs() !== {1'b1, e}) begin
        n_err++; $display("FAIL write_hold%0d: got %h want %h", i, req_obs(), {1'b1, e});
      end
    end
    accept();
    respond(32'h0, 2'd0, ok);
    n_cmp++;
    if ({ok, dmi_req_valid_o, dmi_resp_ready_o} !== 3'b100) begin
      n_err++; $display("FAIL write_done: got %b want 100", {ok, dmi_req_valid_o, dmi_resp_ready_o});
    end
    exp_dtmcs_q.push_back(32'h0000_1071);
    scan_dtmcs(32'h0, dd);
    n_cmp++;
    if (dd !== pop_dtmcs()) begin
      n_err++; $display("FAIL write_dmistat: got %h want 00001071", dd);
    end
  endtask

  task automatic test_dmi_read();
    logic [DW-1:0] dout, ed;
    req_t          e;
    logic          ok;
    exp_dmi_q.push_back({7'h10, 32'hDEAD_BEEF, 2'b00});
    exp_req_q.push_back('{addr: 7'h11, op: 2'd1, data: 32'hDEAD_BEEF});
    scan_dmi({7'h11, 32'h0, 2'b01}, dout);
    ed = pop_dmi();
    n_cmp++;
    if (dout !== ed) begin
      n_err++; $display("FAIL read_capture0: got %h want %h", dout, ed);
    end
    e = pop_req();
    n_cmp++;
    if (req_obs() !== {1'b1, e}) begin
      n_err++; $display("FAIL read_req: got %h want %h", req_obs(), {1'b1, e});
    end
    accept();
    respond(32'h1234_5678, 2'd0, ok);
    exp_dmi_q.push_back({7'h11, 32'h1234_5678, 2'b00});
    scan_dmi({7'h00, 32'h0, 2'b00}, dout);
    ed = pop_dmi();
    n_cmp++;
    if ({ok, dout} !== {1'b1, ed}) begin
      n_err++; $display("FAIL read_result: got %h want %h", {ok, dout}, {1'b1, ed});
    end
    n_cmp++;
    if (dmi_req_valid_o !== 1'b0) begin
      n_err++; $display("FAIL read_nop_noreq: got %b want 0", dmi_req_valid_o);
    end
  endtask

  task automatic test_busy();
    logic [DW-1:0] dout, ed;
    logic [31:0]   dd, edd;
    req_t          e;
    logic          ok;
    exp_dmi_q.push_back({7'h11, 32'h1234_5678, 2'b00});
    exp_req_q.push_back('{addr: 7'h22, op: 2'd1, data: 32'h1234_5678});
    scan_dmi({7'h22, 32'h0, 2'b01}, dout);
    ed = pop_dmi();
    e = pop_req();
    n_cmp++;
    if ({dout, req_obs()} !== {ed, 1'b1, e}) begin
      n_err++; $display("FAIL busy_setup: got %h want %h", {dout, req_obs()}, {ed, 1'b1, e});
    end
    accept();
    exp_dmi_q.push_back({7'h22, 32'h1234_5678, 2'b11});
    scan_dmi({7'h33, 32'h0, 2'b01}, dout);
    ed = pop_dmi();
    n_cmp++;
    if (dout !== ed) begin
      n_err++; $display("FAIL busy_capture: got %h want %h", dout, ed);
    end
    n_cmp++;
    if ({dmi_req_valid_o, dmi_resp_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL busy_update_dropped: got %b want 01", {dmi_req_valid_o, dmi_resp_ready_o});
    end
    respond(32'hAAAA_5555, 2'd2, ok);
    exp_dmi_q.push_back({7'h22, 32'hAAAA_5555, 2'b11});
    scan_dmi({7'h33, 32'h0, 2'b01}, dout);
    ed = pop_dmi();
    n_cmp++;
    if ({ok, dout, dmi_req_valid_o} !== {1'b1, ed, 1'b0}) begin
      n_err++; $display("FAIL busy_sticky_ignored: got %h want %h", {ok, dout, dmi_req_valid_o}, {1'b1, ed, 1'b0});
    end
    exp_dtmcs_q.push_back(32'h0000_1C71);
    exp_dtmcs_q.push_back(32'h0000_1071);
    scan_dtmcs(32'h0001_0000, dd);
    edd = pop_dtmcs();
    n_cmp++;
    if (dd !== edd) begin
      n_err++; $display("FAIL busy_dmistat3: got %h want %h", dd, edd);
    end
    scan_dtmcs(32'h0, dd);
    edd = pop_dtmcs();
    n_cmp++;
    if (dd !== edd) begin
      n_err++; $display("FAIL dmireset_clears: got %h want %h", dd, edd);
    end
    exp_dmi_q.push_back({7'h22, 32'hAAAA_5555, 2'b00});
    exp_req_q.push_back('{addr: 7'h05, op: 2'd1, data: 32'hAAAA_5555});
    scan_dmi({7'h05, 32'h0, 2'b01}, dout);
    ed = pop_dmi();
    e = pop_req();
    n_cmp++;
    if ({dout, req_obs()} !== {ed, 1'b1, e}) begin
      n_err++; $display("FAIL read_after_dmireset: got %h want %h", {dout, req_obs()}, {ed, 1'b1, e});
    end
    accept();
    respond(32'h0BAD_F00D, 2'd0, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL read_after_dmireset_resp: got %b want 1", ok);
    end
  endtask

  task automatic test_resp_error();
    logic [DW-1:0] dout, ed;
    logic [31:0]   dd, edd;
    req_t          e;
    exp_dmi_q.push_back({7'h05, 32'h0BAD_F00D, 2'b00});
    exp_req_q.push_back('{addr: 7'h06, op: 2'd1, data: 32'h0BAD_F00D});
    scan_dmi({7'h06, 32'h0, 2'b01}, dout);
    ed = pop_dmi();
    e = pop_req();
    n_cmp++;
    if ({dout, req_obs()} !== {ed, 1'b1, e}) begin
      n_err++; $display("FAIL err_setup: got %h want %h", {dout, req_obs()}, {ed, 1'b1, e});
    end
    accept();
    n_cmp++;
    if (dmi_resp_ready_o !== 1'b1) begin
      n_err++; $display("FAIL err_wait_state: got %b want 1", dmi_resp_ready_o);
    end
    // Failed response and a busy update on the same edge: the failure wins.
    dmi_select_i = 1'b1; update_i = 1'b1;
    dmi_resp_valid_i = 1'b1; dmi_resp_resp_i = 2'd2; dmi_resp_data_i = 32'hCAFE_F00D;
    tick();
    dmi_select_i = 1'b0; update_i = 1'b0;
    dmi_resp_valid_i = 1'b0; dmi_resp_resp_i = 2'd0;
    exp_dtmcs_q.push_back(32'h0000_1871);
    scan_dtmcs(32'h0, dd);
    edd = pop_dtmcs();
    n_cmp++;
    if (dd !== edd) begin
      n_err++; $display("FAIL err_dmistat2: got %h want %h", dd, edd);
    end
    exp_dmi_q.push_back({7'h06, 32'hCAFE_F00D, 2'b10});
    scan_dmi({7'h00, 32'h0, 2'b00}, dout);
    ed = pop_dmi();
    n_cmp++;
    if (dout !== ed) begin
      n_err++; $display("FAIL err_dmi_op2: got %h want %h", dout, ed);
    end
    exp_dtmcs_q.push_back(32'h0000_1871);
    scan_dtmcs(32'h0001_0000, dd);
    edd = pop_dtmcs();
    n_cmp++;
    if (dd !== edd) begin
      n_err++; $display("FAIL err_before_clear: got %h want %h", dd, edd);
    end
  endtask

  task automatic test_hardreset();
    logic [DW-1:0] dout, ed;
    logic [31:0]   dd, edd;
    req_t          e;
    exp_dmi_q.push_back({7'h06, 32'hCAFE_F00D, 2'b00});
    exp_req_q.push_back('{addr: 7'h40, op: 2'd2, data: 32'h55AA_55AA});
    scan_dmi({7'h40, 32'h55AA_55AA, 2'b10}, dout);
    ed = pop_dmi();
    e = pop_req();
    n_cmp++;
    if ({dout, req_obs()} !== {ed, 1'b1, e}) begin
      n_err++; $display("FAIL hr_setup: got %h want %h", {dout, req_obs()}, {ed, 1'b1, e});
    end
    exp_dtmcs_q.push_back(32'h0000_1071);
    scan_dtmcs(32'h0002_0000, dd);
    edd = pop_dtmcs();
    n_cmp++;
    if ({dd, dmi_req_valid_o, dmi_resp_ready_o, dmi_clear_o} !== {edd, 3'b001}) begin
      n_err++; $display("FAIL hr_drop: got %h want %h", {dd, dmi_req_valid_o, dmi_resp_ready_o, dmi_clear_o}, {edd, 3'b001});
    end
    tick();
    n_cmp++;
    if ({dmi_req_valid_o, dmi_clear_o} !== 2'b00) begin
      n_err++; $display("FAIL hr_pulse_width: got %b want 00", {dmi_req_valid_o, dmi_clear_o});
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] dout, ed;
    req_t          e;
    exp_dmi_q.push_back({7'h40, 32'h55AA_55AA, 2'b00});
    exp_req_q.push_back('{addr: 7'h7F, op: 2'd2, data: 32'hFFFF_FFFF});
    scan_dmi({7'h7F, 32'hFFFF_FFFF, 2'b10}, dout);
    ed = pop_dmi();
    e = pop_req();
    n_cmp++;
    if ({dout, req_obs()} !== {ed, 1'b1, e}) begin
      n_err++; $display("FAIL ar_setup: got %h want %h", {dout, req_obs()}, {ed, 1'b1, e});
    end
    dtmcs_select_i = 1'b1;
    capture_i = 1'b1; tick(); capture_i = 1'b0;
    tdi_i = 1'b1; shift_i = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (dtmcs_tdo_o !== 1'b1) begin
      n_err++; $display("FAIL ar_midshift_tdo: got %b want 1", dtmcs_tdo_o);
    end
    #3;
    trst_i = 1'b1;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL ar_async_clear: got %h want 0", all_outs());
    end
    shift_i = 1'b0; tdi_i = 1'b0; dtmcs_select_i = 1'b0;
    @(negedge tck_i); trst_i = 1'b0;
    n_cmp++;
    if (exp_req_q.size() + exp_dmi_q.size() + exp_dtmcs_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d want 0", exp_req_q.size() + exp_dmi_q.size() + exp_dtmcs_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_dtmcs();
    test_dmi_write();
    test_dmi_read();
    test_busy();
    test_resp_error();
    test_hardreset();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmi_jtag_dr.md
Name: dmi_jtag_dr

Overview:
- Data-register back end of the debug transport module (DTM).
- Sits directly downstream of the JTAG TAP and consumes its capture/shift/update strobes, TDI and DR selects.
- Implements the DTMCS and DMI data registers defined by the RISC-V debug spec 0.13, and returns their serial TDO bits to the TAP output mux.
- Converts completed DMI scans into a valid/ready request/response transaction toward the debug module; any CDC stage lives downstream.

Parameters:
AddrWidth, 7, DMI address width (DTMCS.abits); DMI DR length is AddrWidth+34.
IdleCycles, 3'd1, value reported in DTMCS.idle.

Ports:
tck_i  in  1  JTAG clock; all state is on the rising edge.
trst_i  in  1  asynchronous active-high reset.
capture_i  in  1  TAP CaptureDr strobe.
shift_i  in  1  TAP ShiftDr strobe.
update_i  in  1  TAP UpdateDr strobe.
tdi_i  in  1  serial data in.
dtmcs_select_i  in  1  DTMCS instruction active.
dtmcs_tdo_o  out  1  DTMCS shift register bit 0.
dmi_select_i  in  1  DMIACCESS instruction active.
dmi_tdo_o  out  1  DMI shift register bit 0.
dmi_clear_o  out  1  one-cycle pulse on dmihardreset.
dmi_req_valid_o  out  1  request valid.
dmi_req_ready_i  in  1  request accepted.
dmi_req_addr_o  out  AddrWidth  request address.
dmi_req_op_o  out  2  dtm_op_e (1 = read, 2 = write).
dmi_req_data_o  out  32  write data.
dmi_resp_valid_i  in  1  response valid.
dmi_resp_ready_o  out  1  response accepted.
dmi_resp_data_i  in  32  read data.
dmi_resp_resp_i  in  2  0 = ok, 2 = failed, 3 = busy.

Behaviour:
- Reset (asynchronous, active-high):
  - All shift registers, address_q and data_q are cleared to 0.
  - error_q = 0; FSM = Idle.
  - All outputs are 0.
- DTMCS register, 32 bits:
  - Capture loads {14'b0, hardreset 0, dmireset 0, 1'b0, IdleCycles, error_q[1:0], AddrWidth[5:0], 4'd1}.
  - Shift is a right shift with tdi_i entering at bit 31; dtmcs_tdo_o = bit 0.
  - On update, bit 16 (dmireset) clears error_q.
  - On update, bit 17 (dmihardreset) clears error_q, forces the FSM to Idle, drops valid/ready and pulses dmi_clear_o the following cycle.
  - Hardreset takes priority over every other event in that cycle.
- DMI register, AddrWidth+34 bits, laid out {addr, data[31:0], op[1:0]}:
  - Capture loads {address_q, data_q, error_q}.
  - Shift is a right shift; dmi_tdo_o = bit 0.
  - Capture while FSM ≠ Idle sets error_q = 3 (busy), and the captured op field reads 3.
- FSM states: Idle, Read, WaitRead, Write, WaitWrite.
  - Idle: on update_i & dmi_select_i & error_q == 0:
    - op = 1 → latch address, go to Read.
    - op = 2 → latch address and data, go to Write.
    - op 0 or 3 → no action.
    - If error_q ≠ 0, the update is ignored.
  - Read / Write: dmi_req_valid_o = 1, with op, addr and data held stable. On dmi_req_ready_i, go to WaitRead / WaitWrite the next cycle.
  - WaitRead / WaitWrite: dmi_resp_ready_o = 1. On dmi_resp_valid_i:
    - WaitRead only: data_q <= dmi_resp_data_i.
    - If dmi_resp_resp_i ≠ 0 and error_q == 0, set error_q <= dmi_resp_resp_i.
    - Go to Idle.
  - Update with dmi_select_i while FSM ≠ Idle: error_q <= 3 if it was 0; the new op is dropped.
- error_q is sticky:
  - Only dmireset or dmihardreset clear it.
  - A nonzero value is never overwritten by a different nonzero value.
- Latency:
  - Request valid asserts 1 cycle after update.
  - Minimum round trip is 3 tck cycles (valid → ready → response → Idle).
- Simultaneous events:
  - capture, shift and update are mutually exclusive by TAP construction.
  - If a response and a busy-update arrive in the same cycle, the response error wins; busy applies only if the result is still 0.
- Select inputs sampled low: the corresponding register holds its value.

Decomposition:
- Package dm_pkg holds:
  - dtm_op_e (Nop 0, Read 1, Write 2).
  - dmi_req_t and dmi_resp_t.
  - dtmcs_t packed struct.
  - DTM version constant 4'd1.
  - Response codes Success 0, Failed 2, Busy 3.
- No sub-module; the FSM and both shift registers live in one module.

Test Plan:
- Reset, then DTMCS capture and 32 shifts with AddrWidth = 7 → dtmcs_tdo_o stream equals 0x00001071 LSB-first.
- DMI write: scan addr 0x10, data 0xDEADBEEF, op 2, then update.
  - Required: dmi_req_valid_o next cycle with addr 0x10, op 2, data 0xDEADBEEF.
  - Hold ready low for 3 cycles → outputs stable.
  - Ready, then response resp 0 → Idle, error_q = 0.
- DMI read of 0x11, response data 0x12345678 → next capture shifts out {0x11, 0x12345678, 2'b00}.
- Capture while in WaitRead → op field 3. A following update op 1 is ignored; no new request is issued.
  - DTMCS dmireset (bit 16) → dmistat reads 0 and a new read is accepted.
- Response resp 2 → dmistat = 2. A later busy event leaves it at 2.
- Hardreset mid-Write with valid high → valid drops next cycle, dmi_clear_o pulses exactly 1 cycle, FSM Idle.
- Assert trst_i mid-shift → all outputs 0 immediately, without a clock edge.
